// File: rtl/rfdc_capture.sv
// Captures NUM_SAMPLES signed ADC samples after arm, tracks the peak, and serves registered reads (1-cycle latency).
// The stream is never back-pressured: tready is high from the first clock after reset, and beats outside a capture are dropped.
// Optional RFDC_CAPTURE_TRIG_EN: an armed capture waits for a beat with any lane >= trig_level.
module rfdc_capture #(
    parameter int DATA_WIDTH        = 16,
    parameter int NUM_SAMPLES       = 64,
    parameter int SAMPLES_PER_CYCLE = 5,
    localparam int AW = (NUM_SAMPLES > 1) ? $clog2(NUM_SAMPLES) : 1
) (
    input  logic                                    clk,
    input  logic                                    rst_n,
    input  logic                                    arm,
    input  logic                                    abort,
`ifdef RFDC_CAPTURE_TRIG_EN
    input  logic [DATA_WIDTH-1:0]                   trig_level,
`endif
    input  logic [DATA_WIDTH*SAMPLES_PER_CYCLE-1:0] s_axis_tdata,
    input  logic                                    s_axis_tvalid,
    output logic                                    s_axis_tready,
    output logic                                    busy,
    output logic                                    done,
    output logic signed [DATA_WIDTH-1:0]            peak,
    input  logic                                    rd_en,
    input  logic [AW-1:0]                           rd_addr,
    output logic [DATA_WIDTH-1:0]                   rd_data,
    output logic                                    rd_valid
);
    localparam int CW = $clog2(NUM_SAMPLES + SAMPLES_PER_CYCLE + 1);
    localparam logic [CW-1:0] NUM_C = CW'(NUM_SAMPLES);
    localparam logic [CW-1:0] SPC_C = CW'(SAMPLES_PER_CYCLE);
    localparam logic [AW:0]   NUM_A = (AW+1)'(NUM_SAMPLES);
    localparam logic signed [DATA_WIDTH-1:0] PEAK_MIN = {1'b1, {(DATA_WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {S_IDLE, S_ARMED, S_CAPTURE, S_DONE} state_t;

    state_t                       state;
    logic [CW-1:0]                wr_cnt;
    logic [DATA_WIDTH-1:0]        mem [NUM_SAMPLES];

    logic signed [DATA_WIDTH-1:0] lane     [SAMPLES_PER_CYCLE];
    logic [CW-1:0]                lane_idx [SAMPLES_PER_CYCLE];
    logic                         lane_ok  [SAMPLES_PER_CYCLE];
    logic signed [DATA_WIDTH-1:0] beat_max;
    logic                         beat_acc;
    logic                         trig_hit;
    logic                         wr_fire;
    logic [CW-1:0]                cnt_sum;
    logic [CW-1:0]                cnt_next;
    logic                         rd_addr_ok;

    // wr_cnt is cleared on arm, so the armed-start beat naturally lands at index 0.
    always_comb begin
        beat_acc = s_axis_tvalid && s_axis_tready;
        beat_max = peak;
        trig_hit = 1'b0;
        for (int i = 0; i < SAMPLES_PER_CYCLE; i++) begin
            lane[i]     = s_axis_tdata[i*DATA_WIDTH +: DATA_WIDTH];
            lane_idx[i] = wr_cnt + CW'(i);
            lane_ok[i]  = lane_idx[i] < NUM_C;
            if (lane_ok[i] && (lane[i] > beat_max))
                beat_max = lane[i];
`ifdef RFDC_CAPTURE_TRIG_EN
            if (lane[i] >= $signed(trig_level))
                trig_hit = 1'b1;
`else
            trig_hit = 1'b1;
`endif
        end
        wr_fire    = beat_acc && !abort &&
                     ((state == S_CAPTURE) || ((state == S_ARMED) && trig_hit));
        cnt_sum    = wr_cnt + SPC_C;
        cnt_next   = (cnt_sum >= NUM_C) ? NUM_C : cnt_sum;
        rd_addr_ok = {1'b0, rd_addr} < NUM_A;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= S_IDLE;
            s_axis_tready <= 1'b0;
            busy          <= 1'b0;
            done          <= 1'b0;
            peak          <= PEAK_MIN;
            wr_cnt        <= '0;
        end else begin
            s_axis_tready <= 1'b1;
            case (state)
                S_IDLE, S_DONE: begin
                    if (arm && !abort) begin
                        state  <= S_ARMED;
                        busy   <= 1'b1;
                        done   <= 1'b0;
                        wr_cnt <= '0;
                        peak   <= PEAK_MIN;
                    end
                end
                S_ARMED, S_CAPTURE: begin
                    if (abort) begin
                        state <= S_IDLE;
                        busy  <= 1'b0;
                    end else if (wr_fire) begin
                        wr_cnt <= cnt_next;
                        peak   <= beat_max;
                        if (cnt_next == NUM_C) begin
                            state <= S_DONE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end else begin
                            state <= S_CAPTURE;
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Buffer storage carries no reset; lanes past the end of the block are dropped.
    always_ff @(posedge clk) begin
        if (wr_fire) begin
            for (int i = 0; i < SAMPLES_PER_CYCLE; i++) begin
                if (lane_ok[i])
                    mem[lane_idx[i][AW-1:0]] <= lane[i];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_valid <= 1'b0;
            rd_data  <= '0;
        end else begin
            rd_valid <= rd_en;
            if (rd_en)
                rd_data <= rd_addr_ok ? mem[rd_addr] : '0;
        end
    end

endmodule

// File: doc/rfdc_capture.md
Name: rfdc_capture

Overview:
- AXI-Stream slave that receives packed multi-sample words from the RF ADC path. Each word carries SAMPLES_PER_CYCLE signed samples, lane 0 first.
- On an arm request it captures a block of NUM_SAMPLES consecutive samples into an internal buffer and tracks the peak sample value.
- The buffer is read back through a simple registered read port for software or loopback checking.
- It is the receive-side counterpart of the DAC sample driver and sits between the RF data converter ADC stream and the control/readout logic.

Parameters:
- DATA_WIDTH, 16, bits per signed sample.
- NUM_SAMPLES, 64, capture depth in samples; must be at least 1.
- SAMPLES_PER_CYCLE, 5, samples packed per AXI beat; must be at least 1.

Ports:
- clk  input  1  single clock for all logic.
- rst_n  input  1  asynchronous active-low reset.
- arm  input  1  single-cycle request to start a new capture.
- abort  input  1  cancels an armed or active capture.
- s_axis_tdata  input  DATA_WIDTH*SAMPLES_PER_CYCLE  packed samples; lane i is bits [i*DATA_WIDTH +: DATA_WIDTH].
- s_axis_tvalid  input  1  beat valid.
- s_axis_tready  output  1  beat accepted.
- busy  output  1  high in ARMED or CAPTURE.
- done  output  1  high in DONE.
- peak  output  DATA_WIDTH  signed maximum of the stored samples.
- rd_en  input  1  read strobe.
- rd_addr  input  $clog2(NUM_SAMPLES)  sample index to read.
- rd_data  output  DATA_WIDTH  registered read data.
- rd_valid  output  1  read data valid.

Behaviour:
- Reset values: all state registers reset asynchronously.
  - State is IDLE.
  - s_axis_tready=0, busy=0, done=0, rd_valid=0, rd_data=0.
  - peak = most-negative value.
  - Write count = 0.
  - Buffer contents are not reset.
- s_axis_tready: registered. It goes to 1 on the first clock after reset release and stays 1 permanently. The ADC is never back-pressured.
- Beats accepted outside CAPTURE/ARMED-start are discarded.
- A beat is accepted when tvalid && tready.
- State machine:
  - IDLE: arm -> ARMED.
  - ARMED: the first accepted beat is stored at sample indices 0..SAMPLES_PER_CYCLE-1, and the state goes to CAPTURE (or to DONE if NUM_SAMPLES <= SAMPLES_PER_CYCLE).
  - CAPTURE: each accepted beat writes lane i to index wr_cnt+i only when wr_cnt+i < NUM_SAMPLES. Excess lanes of the final beat are dropped. wr_cnt advances by SAMPLES_PER_CYCLE, saturating at NUM_SAMPLES. When wr_cnt reaches NUM_SAMPLES, the state goes to DONE on that same clock edge.
  - DONE: arm -> ARMED, which clears done.
- arm while in ARMED or CAPTURE is ignored.
- abort in ARMED or CAPTURE -> IDLE on the next edge; done stays 0.
- abort has priority over a beat accepted in the same cycle; that beat is not written.
- abort in IDLE or DONE has no effect.
- Simultaneous arm and abort: abort wins.
- wr_cnt width is $clog2(NUM_SAMPLES+SAMPLES_PER_CYCLE+1); the comparison is unsigned.
- peak:
  - Loaded with the most-negative value on the ARMED transition.
  - Updated with the signed maximum of peak and every written lane in the same edge as the write.
  - Dropped lanes do not contribute.
  - Stable and meaningful in DONE.
- Read port:
  - rd_en at cycle N gives rd_data and rd_valid=1 at cycle N+1.
  - rd_valid is 0 otherwise; rd_data holds its last value.
  - rd_addr >= NUM_SAMPLES returns 0.
  - Reads are permitted in any state. During capture they return current buffer contents, which may be stale.
  - A read and a write to the same index in the same cycle returns the old value.
- Reset asserted mid-capture returns to IDLE immediately; partial buffer contents are left undefined.

Optional Feature:
- Macro: RFDC_CAPTURE_TRIG_EN.
- Defined:
  - Adds input port trig_level [DATA_WIDTH-1:0] (signed).
  - In ARMED, accepted beats are discarded until a beat has any lane with signed value >= trig_level.
  - That beat is stored starting at index 0 from lane 0; the full beat is kept, including lanes before the triggering lane.
  - Then the state goes to CAPTURE.
  - busy remains 1 while waiting.
- Not defined:
  - No trig_level port.
  - Capture begins on the first accepted beat after arm, as described above.

Test Plan:
- Capture, defaults: reset, arm; stream 13 beats whose lane i of beat b equals 5b+i.
  - done rises on the edge of beat 12.
  - Reading indices 0..63 returns 0..63.
  - Sample 64 is dropped; peak = 63.
- Continuous stream: tvalid held high, tvalid toggling 1-0-1 mid-capture.
  - Only valid beats are stored; tready stays 1 throughout.
  - Beats sent before arm never appear in the buffer.
- Abort: arm, send 4 beats, assert abort with a valid beat in the same cycle.
  - State is IDLE, busy=0, done=0.
  - Re-arm and capture completes normally with new data.
- Read port: after a full capture, rd_en with addresses 0, 63, then 64 on consecutive cycles.
  - rd_data = buf[0], buf[63], then 0, each one cycle later with rd_valid=1.
- Reset mid-capture: drop rst_n after 6 beats.
  - All outputs return to reset values immediately, with no wait for a clock edge.
  - tready returns to 1 one clock after release.
- Trigger (RFDC_CAPTURE_TRIG_EN): trig_level=1000; send beats with all lanes at -5, then one beat with lane 3 = 1200.
  - Buffer index 3 = 1200, indices 0..2 = -5.
  - Earlier beats are not stored; peak >= 1200.
